// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared state encodings and decade constants for the stopwatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         NUM_DIGITS = 4;

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// ============================================================================
// Module   : bcd_digit
// Brief    : One decimal decade; wraps 9->0 and raises carry while doing so.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       CLK0,
  input  logic       RST,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (en) begin
      q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge CLK0 or posedge RST) begin
    if (RST) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = en && (q_q == BCD_MAX);

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Run/pause/lap/clear control for a 4-decade BCD counter with a
//            one-hot multiplexed digit scan.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE = 10,
  parameter int SCAN_DIV = 4
) (
  input  logic        CLK0,
  input  logic        RST,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clr,
  output logic [15:0] bcd_out,
  output logic        running,
  output logic        lap_held,
  output logic        ovf,
  output logic        tick,
  output logic [3:0]  an_sel,
  output logic [3:0]  digit_out
);

  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  state_e              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [15:0]         lap_q, lap_d;
  logic                lap_held_q, lap_held_d;
  logic                ovf_q, ovf_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [3:0]          an_sel_q, an_sel_d;

  logic                tick_now;
  logic                clr_go;
  logic [15:0]         count;
  logic [NUM_DIGITS:0] en_chain;

  assign tick_now    = (state_q == S_RUN) && (pre_q == PRE_LAST);
  assign clr_go      = clr && ((state_q == S_RUN) || (state_q == S_PAUSE));
  assign en_chain[0] = tick_now;

  // Digit clear overrides any increment arriving in the same cycle.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .CLK0  (CLK0),
        .RST   (RST),
        .clr   (clr_go),
        .en    (en_chain[gi]),
        .q     (count[4*gi +: 4]),
        .carry (en_chain[gi+1])
      );
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    lap_d      = lap_q;
    lap_held_d = lap_held_q;
    ovf_d      = ovf_q | en_chain[NUM_DIGITS];

    case (state_q)
      S_IDLE: begin
        pre_d = '0;
        if (start_stop) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A pausing cycle freezes the prescaler unless it is wrapping on a tick.
        if (tick_now) begin
          pre_d = '0;
        end else if (!start_stop) begin
          pre_d = pre_q + PRE_W'(1);
        end
        if (start_stop) begin
          state_d = S_PAUSE;
        end else if (lap) begin
          if (!lap_held_q) begin
            lap_d      = count;
            lap_held_d = 1'b1;
          end else begin
            lap_held_d = 1'b0;
          end
        end
      end
      S_PAUSE: begin
        if (start_stop) begin
          state_d = S_RUN;
        end else if (lap) begin
          lap_held_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pre_d   = '0;
      end
    endcase

    if (clr_go) begin
      state_d    = S_IDLE;
      pre_d      = '0;
      lap_held_d = 1'b0;
      ovf_d      = 1'b0;
    end
  end

  always_comb begin
    scan_d   = scan_q + SCAN_W'(1);
    an_sel_d = an_sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d   = '0;
      an_sel_d = {an_sel_q[2:0], an_sel_q[3]};
    end
  end

  always_ff @(posedge CLK0 or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      lap_q      <= 16'h0000;
      lap_held_q <= 1'b0;
      ovf_q      <= 1'b0;
      scan_q     <= '0;
      an_sel_q   <= 4'b0001;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      lap_q      <= lap_d;
      lap_held_q <= lap_held_d;
      ovf_q      <= ovf_d;
      scan_q     <= scan_d;
      an_sel_q   <= an_sel_d;
    end
  end

  assign bcd_out  = lap_held_q ? lap_q : count;
  assign running  = (state_q == S_RUN);
  assign lap_held = lap_held_q;
  assign ovf      = ovf_q;
  assign tick     = tick_now;
  assign an_sel   = an_sel_q;

  always_comb begin
    digit_out = bcd_out[3:0];
    case (an_sel_q)
      4'b0010: digit_out = bcd_out[7:4];
      4'b0100: digit_out = bcd_out[11:8];
      4'b1000: digit_out = bcd_out[15:12];
      default: digit_out = bcd_out[3:0];
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Directed self-checking bench for stopwatch_ctrl (PRESCALE=4, SCAN_DIV=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

  logic        CLK0;
  logic        RST;
  logic        start_stop;
  logic        lap;
  logic        clr;
  logic [15:0] bcd_out;
  logic        running;
  logic        lap_held;
  logic        ovf;
  logic        tick;
  logic [3:0]  an_sel;
  logic [3:0]  digit_out;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_ctrl #(
    .PRESCALE (4),
    .SCAN_DIV (2)
  ) dut (
    .CLK0       (CLK0),
    .RST        (RST),
    .start_stop (start_stop),
    .lap        (lap),
    .clr        (clr),
    .bcd_out    (bcd_out),
    .running    (running),
    .lap_held   (lap_held),
    .ovf        (ovf),
    .tick       (tick),
    .an_sel     (an_sel),
    .digit_out  (digit_out)
  );

  initial begin
    CLK0 = 1'b0;
    forever #5 CLK0 = ~CLK0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK0);
      #1;
    end
  endtask

  function automatic logic [3:0] nib_of(input logic [15:0] v, input logic [3:0] sel);
    case (sel)
      4'b0010: return v[7:4];
      4'b0100: return v[11:8];
      4'b1000: return v[15:12];
      default: return v[3:0];
    endcase
  endfunction

  initial begin
    int tk;
    int first;
    logic [3:0] an_exp [8];
    an_exp[0] = 4'b0001; an_exp[1] = 4'b0010; an_exp[2] = 4'b0010; an_exp[3] = 4'b0100;
    an_exp[4] = 4'b0100; an_exp[5] = 4'b1000; an_exp[6] = 4'b1000; an_exp[7] = 4'b0001;

    RST = 1'b0; start_stop = 1'b0; lap = 1'b0; clr = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("rst_bcd", 32'(bcd_out), 32'h0000);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_an_sel", 32'(an_sel), 32'b0001);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    step(2);
    @(negedge CLK0);
    RST = 1'b0;

    // Start and measure tick cadence over 40 RUN cycles.
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    chk("run_running", 32'(running), 32'd1);
    tk = 0; first = -1;
    for (int i = 0; i < 40; i++) begin
      if (tick) begin
        if (tk == 0) first = i;
        tk++;
      end
      step(1);
    end
    chk("run_tick_count", 32'(tk), 32'd10);
    chk("run_first_tick", 32'(first), 32'd3);
    chk("run_bcd_0010", 32'(bcd_out), 32'h0010);
    chk("run_running2", 32'(running), 32'd1);

    // Lap with coincident tick at 0037.
    step(111);
    chk("lap_pre_bcd", 32'(bcd_out), 32'h0037);
    chk("lap_pre_tick", 32'(tick), 32'd1);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("lap_held_set", 32'(lap_held), 32'd1);
    chk("lap_bcd_0037", 32'(bcd_out), 32'h0037);
    step(28);
    chk("lap_frozen_0037", 32'(bcd_out), 32'h0037);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("lap_release", 32'(lap_held), 32'd0);
    chk("lap_live_0045", 32'(bcd_out), 32'h0045);

    // Pause at pre=2, then resume.
    step(1);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    chk("pause_running", 32'(running), 32'd0);
    tk = 0;
    for (int i = 0; i < 20; i++) begin
      if (tick) tk++;
      chk("pause_digit", 32'(digit_out), 32'(nib_of(16'h0045, an_sel)));
      step(1);
    end
    chk("pause_no_tick", 32'(tk), 32'd0);
    chk("pause_bcd", 32'(bcd_out), 32'h0045);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    chk("resume_running", 32'(running), 32'd1);
    chk("resume_tick0", 32'(tick), 32'd0);
    step(1);
    chk("resume_tick1", 32'(tick), 32'd1);
    step(1);
    chk("resume_bcd_0046", 32'(bcd_out), 32'h0046);

    // Carry chain and overflow.
    step(3808);
    chk("bcd_0998", 32'(bcd_out), 32'h0998);
    step(4);
    chk("bcd_0999", 32'(bcd_out), 32'h0999);
    step(4);
    chk("bcd_1000", 32'(bcd_out), 32'h1000);
    step(35996);
    chk("bcd_9999", 32'(bcd_out), 32'h9999);
    chk("ovf_before", 32'(ovf), 32'd0);
    step(3);
    chk("wrap_tick", 32'(tick), 32'd1);
    step(1);
    chk("wrap_bcd", 32'(bcd_out), 32'h0000);
    chk("wrap_ovf", 32'(ovf), 32'd1);
    step(4);
    chk("ovf_sticky_bcd", 32'(bcd_out), 32'h0001);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("lap2_held", 32'(lap_held), 32'd1);

    // clr + start_stop + lap together: clr wins.
    clr = 1'b1; start_stop = 1'b1; lap = 1'b1;
    step(1);
    clr = 1'b0; start_stop = 1'b0; lap = 1'b0;
    chk("clr_running", 32'(running), 32'd0);
    chk("clr_bcd", 32'(bcd_out), 32'h0000);
    chk("clr_lap_held", 32'(lap_held), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    step(5);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("idle_lap_ignored", 32'(lap_held), 32'd0);
    chk("idle_stays", 32'(running), 32'd0);

    // Asynchronous reset in the middle of a run.
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    step(10);
    chk("mid_bcd_0002", 32'(bcd_out), 32'h0002);
    #2 RST = 1'b1;
    #1;
    chk("arst_bcd", 32'(bcd_out), 32'h0000);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_an_sel", 32'(an_sel), 32'b0001);
    chk("arst_digit", 32'(digit_out), 32'd0);
    @(negedge CLK0);
    RST = 1'b0;
    #1;
    chk("scan_0", 32'(an_sel), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("scan_seq", 32'(an_sel), 32'(an_exp[i]));
    end
    chk("post_rst_running", 32'(running), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
